filter_sequencer: RTL and testbench
===================================

Name: filter_sequencer

Overview:
- Time-multiplexes one shared FIR/averaging filter datapath between the left and right audio channels of the codec interface.
- Per stereo frame: pops one frame from the codec read side, runs left then right through the filter, and pushes the filtered pair to the codec write side.
- Sits between the audio codec core and the filter instance, which carries a per-channel history bank.

Parameters:
- WIDTH, 24, sample width in bits (codec and filter data).
- FILT_LAT, 2, cycles from the filt_start cycle to valid filt_dout; legal range 1..15.
- CNT_W, 8, width of the processed-frame counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- read_ready  in  1  codec has a stereo frame available
- read  out  1  one-cycle pop of the codec input frame
- readdata_left  in  WIDTH  codec left input sample
- readdata_right  in  WIDTH  codec right input sample
- write_ready  in  1  codec can accept a frame
- write  out  1  one-cycle push of the output frame
- writedata_left  out  WIDTH  filtered left sample
- writedata_right  out  WIDTH  filtered right sample
- filt_start  out  1  strobe: filter consumes filt_din for bank filt_chan
- filt_chan  out  1  0 = left history bank, 1 = right history bank
- filt_din  out  WIDTH  sample presented to the filter
- filt_dout  in  WIDTH  filter result
- busy  out  1  high in every state except IDLE
- frame_count  out  CNT_W  frames written, wraps

Behaviour:
- Reset: clock is clock; reset is synchronous, active-high. State goes to IDLE. All of read, write, filt_start, filt_chan, busy = 0; filt_din, writedata_*, frame_count = 0; latency counter = 0.
- States: IDLE, RUN_L, WAIT_L, RUN_R, WAIT_R, OUT.
- IDLE:
  - read = read_ready, combinational.
  - When read_ready, latch readdata_left/right into in_l/in_r and go to RUN_L.
- RUN_L (1 cycle):
  - filt_start = 1, filt_chan = 0, filt_din = in_l.
  - Load latency counter with FILT_LAT-1, go to WAIT_L.
- WAIT_L:
  - Hold filt_chan = 0.
  - Decrement the counter each cycle; the cycle it equals 0, capture filt_dout into writedata_left and go to RUN_R.
  - Capture happens exactly FILT_LAT cycles after the RUN_L cycle.
- RUN_R / WAIT_R: identical to RUN_L / WAIT_L with filt_chan = 1 and filt_din = in_r; the capture loads writedata_right, then go to OUT.
- OUT:
  - write = write_ready, combinational.
  - writedata_* held stable from OUT entry until accepted.
  - When write_ready: frame_count increments (wraps at 2^CNT_W-1 to 0); go to IDLE.
  - If write_ready is low, stall indefinitely with no timeout.
- Latency: read cycle = 0; earliest write cycle = 3 + 2*FILT_LAT (7 at default).
- Throughput: at most one frame per 4 + 2*FILT_LAT cycles; the codec FIFO absorbs the slack.
- filt_start is high only in RUN_L/RUN_R, and never twice within FILT_LAT cycles.
- read_ready while not in IDLE: ignored, read stays 0. read and write are never high in the same cycle.
- In IDLE with read_ready and write_ready both high: only read is issued.
- Reset mid-frame: the frame is discarded, no write is issued, and the reset values above apply on the next cycle.
- readdata_* are sampled only in the read cycle; later changes have no effect.

Optional Feature:
- Macro FILTER_SEQ_BYPASS_EN.
- When defined:
  - Input port bypass (1 bit) is added and sampled in the IDLE read cycle.
  - If bypass = 1, the frame skips RUN/WAIT: writedata_* = raw samples, state goes directly to OUT, filt_start stays 0, and filter history is untouched.
  - Earliest write occurs in cycle 1.
  - Changing bypass mid-frame has no effect on that frame.
- When not defined: no bypass port, and every frame is filtered.

Test Plan:
- Reset, then idle with read_ready = 0 for 10 cycles -> all outputs 0, busy = 0, no read/write/filt_start.
- FILT_LAT = 2, write_ready = 1; frame L = 24'h000100, R = 24'h000200; filter model returns din+1 -> read at cycle 0; filt_start at cycles 1 (chan 0) and 4 (chan 1); write at cycle 7 with 24'h000101 / 24'h000201; frame_count = 1.
- Same frame with write_ready low until cycle 20 -> writedata_* held constant cycles 7-20, single write at cycle 20, read stays 0 despite read_ready = 1.
- Assert reset at cycle 5 mid-frame -> no write ever issued, outputs 0 at cycle 6, next frame processes normally.
- 256 back-to-back frames, CNT_W = 8 -> frame_count wraps to 0; read/write never coincide; at most one read per frame.
- FILTER_SEQ_BYPASS_EN defined, bypass = 1, L = 24'hABCDEF -> write at cycle 1 with writedata_left = 24'hABCDEF, filt_start never asserted.

Source files
------------

// File: rtl/filter_sequencer_if.sv
// Codec read/write handshake and shared-filter strobe bundle for filter_sequencer.
// master = the sequencer, slave = the codec/filter side.
interface filter_sequencer_if #(
    parameter int WIDTH = 24
);
    logic             read_ready;
    logic             read;
    logic [WIDTH-1:0] readdata_left;
    logic [WIDTH-1:0] readdata_right;
    logic             write_ready;
    logic             write;
    logic [WIDTH-1:0] writedata_left;
    logic [WIDTH-1:0] writedata_right;
    logic             filt_start;
    logic             filt_chan;
    logic [WIDTH-1:0] filt_din;
    logic [WIDTH-1:0] filt_dout;

    modport master (
        input  read_ready,
        input  readdata_left,
        input  readdata_right,
        input  write_ready,
        input  filt_dout,
        output read,
        output write,
        output writedata_left,
        output writedata_right,
        output filt_start,
        output filt_chan,
        output filt_din
    );

    modport slave (
        output read_ready,
        output readdata_left,
        output readdata_right,
        output write_ready,
        output filt_dout,
        input  read,
        input  write,
        input  writedata_left,
        input  writedata_right,
        input  filt_start,
        input  filt_chan,
        input  filt_din
    );
endinterface

// File: rtl/filter_sequencer.sv
// Time-multiplexes one filter datapath between left and right codec channels, one stereo frame at a time.
// Define FILTER_SEQ_BYPASS_EN to add a bypass input that sends a frame's raw samples straight to the output.
module filter_sequencer #(
    parameter int WIDTH    = 24,
    parameter int FILT_LAT = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
`ifdef FILTER_SEQ_BYPASS_EN
    input  logic             bypass,
`endif
    filter_sequencer_if.master bus,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count
);
    // state  | meaning
    // IDLE   | waiting for a codec frame; read follows read_ready
    // RUN_L  | filt_start for the left sample, load latency counter
    // WAIT_L | count down filter latency, capture left result at zero
    // RUN_R  | filt_start for the right sample, load latency counter
    // WAIT_R | count down filter latency, capture right result at zero
    // OUT    | present filtered pair; write follows write_ready
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RUN_L  = 3'd1;
    localparam logic [2:0] WAIT_L = 3'd2;
    localparam logic [2:0] RUN_R  = 3'd3;
    localparam logic [2:0] WAIT_R = 3'd4;
    localparam logic [2:0] OUT    = 3'd5;

    // Counter reaches zero in the cycle the filter result is valid.
    localparam logic [3:0] LAT_LOAD = 4'(FILT_LAT - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] in_l_q, in_l_d;
    logic [WIDTH-1:0] in_r_q, in_r_d;
    logic [WIDTH-1:0] wd_l_q, wd_l_d;
    logic [WIDTH-1:0] wd_r_q, wd_r_d;
    logic [CNT_W-1:0] fc_q, fc_d;

    logic             read_c;
    logic             write_c;
    logic             start_c;
    logic             chan_c;
    logic [WIDTH-1:0] din_c;
    logic             skip_filter;

`ifdef FILTER_SEQ_BYPASS_EN
    assign skip_filter = bypass;
`else
    assign skip_filter = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_l_d  = in_l_q;
        in_r_d  = in_r_q;
        wd_l_d  = wd_l_q;
        wd_r_d  = wd_r_q;
        fc_d    = fc_q;
        read_c  = 1'b0;
        write_c = 1'b0;
        start_c = 1'b0;
        chan_c  = 1'b0;
        din_c   = '0;

        case (state_q)
            IDLE: begin
                read_c = bus.read_ready;
                if (bus.read_ready) begin
                    in_l_d = bus.readdata_left;
                    in_r_d = bus.readdata_right;
                    if (skip_filter) begin
                        wd_l_d  = bus.readdata_left;
                        wd_r_d  = bus.readdata_right;
                        state_d = OUT;
                    end else begin
                        state_d = RUN_L;
                    end
                end
            end
            RUN_L: begin
                start_c = 1'b1;
                din_c   = in_l_q;
                cnt_d   = LAT_LOAD;
                state_d = WAIT_L;
            end
            WAIT_L: begin
                din_c = in_l_q;
                if (cnt_q == 4'd0) begin
                    wd_l_d  = bus.filt_dout;
                    state_d = RUN_R;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RUN_R: begin
                start_c = 1'b1;
                chan_c  = 1'b1;
                din_c   = in_r_q;
                cnt_d   = LAT_LOAD;
                state_d = WAIT_R;
            end
            WAIT_R: begin
                chan_c = 1'b1;
                din_c  = in_r_q;
                if (cnt_q == 4'd0) begin
                    wd_r_d  = bus.filt_dout;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            OUT: begin
                write_c = bus.write_ready;
                if (bus.write_ready) begin
                    fc_d    = fc_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            in_l_q  <= '0;
            in_r_q  <= '0;
            wd_l_q  <= '0;
            wd_r_q  <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_l_q  <= in_l_d;
            in_r_q  <= in_r_d;
            wd_l_q  <= wd_l_d;
            wd_r_q  <= wd_r_d;
            fc_q    <= fc_d;
        end
    end

    // Handshake strobes are masked while reset is held so no frame is popped or pushed.
    assign bus.read            = read_c & ~reset;
    assign bus.write           = write_c & ~reset;
    assign bus.filt_start      = start_c;
    assign bus.filt_chan       = chan_c;
    assign bus.filt_din        = din_c;
    assign bus.writedata_left  = wd_l_q;
    assign bus.writedata_right = wd_r_q;
    assign busy                = (state_q != IDLE);
    assign frame_count         = fc_q;
endmodule

// File: tb/tb_filter_sequencer.sv
// Self-checking bench for filter_sequencer: directed frames, stall, mid-frame reset, random back-to-back traffic.
// A frame-level reference model predicts every handshake, filter strobe and output word per cycle.
module tb_filter_sequencer;
    localparam int W   = 24;
    localparam int LAT = 2;
    localparam int CW  = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          busy;
    logic [CW-1:0] frame_count;
`ifdef FILTER_SEQ_BYPASS_EN
    logic          bypass = 1'b0;
`endif

    filter_sequencer_if #(.WIDTH(W)) bus ();

    filter_sequencer #(.WIDTH(W), .FILT_LAT(LAT), .CNT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
`ifdef FILTER_SEQ_BYPASS_EN
        .bypass      (bypass),
`endif
        .bus         (bus),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Filter stand-in: result appears exactly LAT cycles after filt_start, junk otherwise.
    int filt_mode = 0;
    function automatic logic [W-1:0] filt_fn(input logic [W-1:0] din, input logic chan);
        if (filt_mode == 0) return din + W'(1);
        return din + W'(1) + (chan ? W'(24'h010000) : W'(0));
    endfunction

    logic [W-1:0] pipe [LAT];
    always @(posedge clock) begin
        pipe[0] <= bus.filt_start ? filt_fn(bus.filt_din, bus.filt_chan) : W'($urandom);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.filt_dout = pipe[LAT-1];

    // Reference model state
    int            cyc = 0;
    logic          rst_seen = 1'b1;
    logic          in_flight = 1'b0;
    logic          cur_byp = 1'b0;
    int            rc = 0;
    int            age;
    int            lat;
    logic          exp_rd, exp_wr, exp_fs;
    logic [W-1:0]  raw_l, raw_r, exp_l, exp_r;
    logic [CW-1:0] exp_fc = '0;
    int            writes_seen = 0;
    int            last_lat = 0;
    logic [W-1:0]  last_wdl, last_wdr;

    initial forever begin
        @(posedge clock);
        cyc++;
        rst_seen = reset;
    end

    initial forever begin
        @(negedge clock);
        if (rst_seen) begin
            in_flight = 1'b0;
            exp_fc    = '0;
            check_eq("rst_busy",  64'(busy), 64'(0));
            check_eq("rst_write", 64'(bus.write), 64'(0));
            check_eq("rst_fstart", 64'(bus.filt_start), 64'(0));
            check_eq("rst_fchan", 64'(bus.filt_chan), 64'(0));
            check_eq("rst_fdin",  64'(bus.filt_din), 64'(0));
            check_eq("rst_wdl",   64'(bus.writedata_left), 64'(0));
            check_eq("rst_wdr",   64'(bus.writedata_right), 64'(0));
            check_eq("rst_fc",    64'(frame_count), 64'(0));
        end
        if (!reset) begin
            age    = cyc - rc;
            lat    = cur_byp ? 1 : 3 + 2 * LAT;
            exp_rd = !in_flight && bus.read_ready;
            exp_wr = in_flight && (age >= lat) && bus.write_ready;
            exp_fs = in_flight && !cur_byp && (age == 1 || age == 2 + LAT);
            check_eq("read",   64'(bus.read), 64'(exp_rd));
            check_eq("write",  64'(bus.write), 64'(exp_wr));
            check_eq("rw_excl", 64'(bus.read & bus.write), 64'(0));
            check_eq("busy",   64'(busy), 64'(in_flight));
            check_eq("fcount", 64'(frame_count), 64'(exp_fc));
            check_eq("fstart", 64'(bus.filt_start), 64'(exp_fs));
            if (exp_fs) begin
                check_eq("fchan", 64'(bus.filt_chan), 64'(age != 1));
                check_eq("fdin",  64'(bus.filt_din), 64'((age == 1) ? raw_l : raw_r));
            end
            if (in_flight && age >= lat) begin
                check_eq("wdl_hold", 64'(bus.writedata_left), 64'(exp_l));
                check_eq("wdr_hold", 64'(bus.writedata_right), 64'(exp_r));
            end
            if (bus.write && exp_wr) begin
                in_flight = 1'b0;
                exp_fc++;
                writes_seen++;
                last_lat = age;
                last_wdl = bus.writedata_left;
                last_wdr = bus.writedata_right;
            end
            if (bus.read && exp_rd) begin
                in_flight = 1'b1;
                rc        = cyc;
                raw_l     = bus.readdata_left;
                raw_r     = bus.readdata_right;
`ifdef FILTER_SEQ_BYPASS_EN
                cur_byp   = bypass;
`else
                cur_byp   = 1'b0;
`endif
                exp_l = cur_byp ? raw_l : filt_fn(raw_l, 1'b0);
                exp_r = cur_byp ? raw_r : filt_fn(raw_r, 1'b1);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_write(input int target, input int budget);
        int n = 0;
        while (writes_seen < target && n < budget) begin
            step();
            bus.readdata_left  = W'($urandom);
            bus.readdata_right = W'($urandom);
            n++;
        end
        if (writes_seen < target) check_eq("write_timeout", 64'(writes_seen), 64'(target));
    endtask

    int ws;
    int target;
    int n;
    logic [CW-1:0] fc0;

    initial begin
        bus.read_ready     = 1'b0;
        bus.write_ready    = 1'b0;
        bus.readdata_left  = '0;
        bus.readdata_right = '0;
        repeat (3) step();
        reset = 1'b0;

        // Idle with nothing to read
        repeat (10) step();
        check_eq("idle_read",  64'(bus.read), 64'(0));
        check_eq("idle_write", 64'(bus.write), 64'(0));
        check_eq("idle_busy",  64'(busy), 64'(0));

        // Directed frame, no back-pressure
        bus.write_ready    = 1'b1;
        bus.read_ready     = 1'b1;
        bus.readdata_left  = 24'h000100;
        bus.readdata_right = 24'h000200;
        step();
        bus.read_ready = 1'b0;
        wait_write(1, 40);
        check_eq("dir_wdl", 64'(last_wdl), 64'(24'h000101));
        check_eq("dir_wdr", 64'(last_wdr), 64'(24'h000201));
        check_eq("dir_lat", 64'(last_lat), 64'(7));
        check_eq("dir_fc",  64'(frame_count), 64'(1));

        // Same frame with write_ready held low until cycle 20, read_ready kept high
        bus.write_ready    = 1'b0;
        bus.read_ready     = 1'b1;
        bus.readdata_left  = 24'h000100;
        bus.readdata_right = 24'h000200;
        repeat (20) begin
            step();
            bus.readdata_left  = W'($urandom);
            bus.readdata_right = W'($urandom);
        end
        bus.write_ready = 1'b1;
        bus.read_ready  = 1'b0;
        wait_write(2, 5);
        check_eq("stall_lat", 64'(last_lat), 64'(20));
        check_eq("stall_wdl", 64'(last_wdl), 64'(24'h000101));
        check_eq("stall_wdr", 64'(last_wdr), 64'(24'h000201));
        check_eq("stall_fc",  64'(frame_count), 64'(2));

        // Reset asserted in cycle 5 of a frame
        bus.read_ready     = 1'b1;
        bus.readdata_left  = W'($urandom);
        bus.readdata_right = W'($urandom);
        step();
        bus.read_ready = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        ws = writes_seen;
        repeat (12) step();
        check_eq("rst_nowrite", 64'(writes_seen), 64'(ws));
        check_eq("rst_fc0",     64'(frame_count), 64'(0));

        bus.read_ready     = 1'b1;
        bus.readdata_left  = 24'h000300;
        bus.readdata_right = 24'h000400;
        step();
        bus.read_ready = 1'b0;
        wait_write(ws + 1, 40);
        check_eq("post_rst_wdl", 64'(last_wdl), 64'(24'h000301));
        check_eq("post_rst_wdr", 64'(last_wdr), 64'(24'h000401));
        check_eq("post_rst_lat", 64'(last_lat), 64'(7));
        check_eq("post_rst_fc",  64'(frame_count), 64'(1));

        // Random back-to-back traffic, enough frames to wrap the counter
        filt_mode = 1;
        fc0       = exp_fc;
        target    = writes_seen + 260;
        n         = 0;
        while (writes_seen < target && n < 20000) begin
            bus.read_ready     = ($urandom_range(7) != 0);
            bus.write_ready    = ($urandom_range(3) != 0);
            bus.readdata_left  = W'($urandom);
            bus.readdata_right = W'($urandom);
`ifdef FILTER_SEQ_BYPASS_EN
            bypass = ($urandom_range(3) == 0);
`endif
            step();
            n++;
        end
        bus.read_ready  = 1'b0;
        bus.write_ready = 1'b0;
        if (writes_seen < target) check_eq("rand_timeout", 64'(writes_seen), 64'(target));
        check_eq("wrap_fc", 64'(frame_count), 64'(CW'(fc0 + CW'(260))));

`ifdef FILTER_SEQ_BYPASS_EN
        // Bypass frame; flipping bypass after the read must not matter
        filt_mode          = 0;
        ws                 = writes_seen;
        bypass             = 1'b1;
        bus.write_ready    = 1'b1;
        bus.read_ready     = 1'b1;
        bus.readdata_left  = 24'hABCDEF;
        bus.readdata_right = 24'h123456;
        step();
        bus.read_ready = 1'b0;
        bypass         = 1'b0;
        wait_write(ws + 1, 10);
        check_eq("byp_lat", 64'(last_lat), 64'(1));
        check_eq("byp_wdl", 64'(last_wdl), 64'(24'hABCDEF));
        check_eq("byp_wdr", 64'(last_wdr), 64'(24'h123456));
`endif

        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
